// File: rtl/mult_pkg.sv
// Shared types and helpers for the iterative radix-4 Booth multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_digit_t;

  function automatic int calc_iter(input int width, input int dpc);
    return ((width / 2 + 1) + dpc - 1) / dpc;
  endfunction

  // Window is {b[2j+1], b[2j], b[2j-1]}; 000 and 111 both encode zero.
  function automatic booth_digit_t booth_encode(input logic [2:0] win);
    booth_digit_t d;
    d.neg = win[2] & ~(win[1] & win[0]);
    d.one = win[1] ^ win[0];
    d.two = (win[2] & ~win[1] & ~win[0]) | (~win[2] & win[1] & win[0]);
    return d;
  endfunction

endpackage

// File: rtl/booth_r4_pp_gen.sv
// One radix-4 Booth partial product: selects 0, +/-A or +/-2A from a 3-bit window.
module booth_r4_pp_gen
  import mult_pkg::*;
#(
  parameter int PW = 514
) (
  input  logic [2:0]    win_i,
  input  logic [PW-1:0] a_i,
  output logic [PW-1:0] pp_o
);

  booth_digit_t  dig;
  logic [PW-1:0] mag;

  always_comb begin
    dig = booth_encode(win_i);
    mag = '0;
    if (dig.one) begin
      mag = a_i;
    end else if (dig.two) begin
      mag = a_i << 1;
    end
    pp_o = dig.neg ? (~mag + PW'(1)) : mag;
  end

endmodule

// File: rtl/multiplier_booth_iterative.sv
// Sequential radix-4 Booth multiplier retiring DIGITS_PER_CYCLE digits per clock,
// with valid/ready handshakes on operand and product sides.
module multiplier_booth_iterative
  import mult_pkg::*;
#(
  parameter int WIDTH            = 256,
  parameter int DIGITS_PER_CYCLE = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int ITER = calc_iter(WIDTH, DIGITS_PER_CYCLE);
  localparam int PW   = 2 * WIDTH + 2;
  localparam int SH   = 2 * DIGITS_PER_CYCLE;
  localparam int BW   = (WIDTH + 3 > SH + 1) ? WIDTH + 3 : SH + 1;
  localparam int CW   = (ITER > 1) ? $clog2(ITER + 1) : 1;

  state_e             state_q, state_d;
  logic [PW-1:0]      a_q, a_d;
  logic [BW-1:0]      b_q, b_d;
  logic [PW-1:0]      acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               busy_q, busy_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic [PW-1:0]      pp [DIGITS_PER_CYCLE];
  logic [PW-1:0]      acc_sum;
  logic               a_ext, b_ext;

  // a_q is pre-shifted and b_q pre-shifted each cycle, so digit k always reads window k.
  for (genvar k = 0; k < DIGITS_PER_CYCLE; k++) begin : g_pp
    logic [PW-1:0] a_k;
    assign a_k = a_q << (2 * k);
    booth_r4_pp_gen #(.PW(PW)) u_pp (
      .win_i (b_q[2*k+2 -: 3]),
      .a_i   (a_k),
      .pp_o  (pp[k])
    );
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    a_ext     = signed_mode & A[WIDTH-1];
    b_ext     = signed_mode & B[WIDTH-1];

    acc_sum = acc_q;
    for (int k = 0; k < DIGITS_PER_CYCLE; k++) begin
      acc_sum = acc_sum + pp[k];
    end

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d     = {{(WIDTH + 2){a_ext}}, A};
          b_d     = {{(BW - WIDTH - 1){b_ext}}, B, 1'b0};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d = acc_sum;
        a_d   = a_q << SH;
        b_d   = $unsigned($signed(b_q) >>> SH);
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ITER - 1)) begin
          state_d   = DONE;
          product_d = acc_sum[2*WIDTH-1:0];
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      product_q   <= '0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      product_q   <= product_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign product   = product_q;

endmodule

// File: tb/tb_multiplier_booth_iterative.sv
// Directed bench: default 256/4 instance plus a small 8-bit, one-iteration instance.
module tb_multiplier_booth_iterative;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, signed_mode, out_valid, out_ready, busy;
  logic [255:0] A, B;
  logic [511:0] product;

  logic         s_in_valid, s_in_ready, s_signed_mode, s_out_valid, s_busy;
  logic [7:0]   s_A, s_B;
  logic [15:0]  s_product;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multiplier_booth_iterative dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .signed_mode(signed_mode), .A(A), .B(B), .out_valid(out_valid),
    .out_ready(out_ready), .product(product), .busy(busy)
  );

  multiplier_booth_iterative #(.WIDTH(8), .DIGITS_PER_CYCLE(5)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .signed_mode(s_signed_mode), .A(s_A), .B(s_B), .out_valid(s_out_valid),
    .out_ready(1'b1), .product(s_product), .busy(s_busy)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic sm, input logic [255:0] a, input logic [255:0] b);
    @(negedge clk);
    chk("in_ready_before_accept", 512'(in_ready), 512'd1);
    in_valid    = 1'b1;
    signed_mode = sm;
    A           = a;
    B           = b;
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    signed_mode = ~sm;
    A           = '1;
    B           = 256'h1234;
  endtask

  task automatic wait_done(input int exp_lat);
    int   n;
    logic busy_bad;
    n        = 0;
    busy_bad = 1'b0;
    while (out_valid !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (busy !== 1'b1) busy_bad = 1'b1;
    end
    chk("latency", 512'(n), 512'(exp_lat));
    chk("busy_during_op", 512'(busy_bad), 512'd0);
  endtask

  task automatic take();
    @(posedge clk);
    #1;
    chk("out_valid_after_take", 512'(out_valid), 512'd0);
    chk("in_ready_after_take", 512'(in_ready), 512'd1);
  endtask

  task automatic small_run(input logic sm, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] exp;
    exp = sm ? ({{8{a[7]}}, a} * {{8{b[7]}}, b}) : ({8'd0, a} * {8'd0, b});
    @(negedge clk);
    chk("s_in_ready", 512'(s_in_ready), 512'd1);
    s_in_valid    = 1'b1;
    s_signed_mode = sm;
    s_A           = a;
    s_B           = b;
    @(posedge clk);
    #1;
    s_in_valid = 1'b0;
    s_A        = ~a;
    @(posedge clk);
    #1;
    chk("s_out_valid", 512'(s_out_valid), 512'd1);
    chk("s_product", 512'(s_product), 512'(exp));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [255:0] min_v;
    rst_n         = 1'b0;
    in_valid      = 1'b0;
    signed_mode   = 1'b0;
    A             = '0;
    B             = '0;
    out_ready     = 1'b1;
    s_in_valid    = 1'b0;
    s_signed_mode = 1'b0;
    s_A           = '0;
    s_B           = '0;
    min_v         = 256'd1 << 255;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 512'(in_ready), 512'd0);
    chk("reset_out_valid", 512'(out_valid), 512'd0);
    chk("reset_busy", 512'(busy), 512'd0);
    chk("reset_product", product, 512'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_reset", 512'(in_ready), 512'd1);

    start(1'b0, 256'd3, 256'd5);
    wait_done(33);
    chk("u_3x5", product, 512'd15);
    take();

    start(1'b0, '1, '1);
    wait_done(33);
    chk("u_max_max", product, {{255{1'b1}}, 1'b0, {255{1'b0}}, 1'b1});
    take();

    start(1'b1, '1, 256'd1);
    wait_done(33);
    chk("s_neg1_x_1", product, {512{1'b1}});
    take();

    start(1'b1, min_v, min_v);
    wait_done(33);
    chk("s_min_min", product, 512'd1 << 510);
    take();

    start(1'b1, '1, '1);
    wait_done(33);
    chk("s_neg1_neg1", product, 512'd1);
    take();

    out_ready = 1'b0;
    start(1'b0, 256'd100, 256'd200);
    wait_done(33);
    chk("bp_product", product, 512'd20000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      A        = {8{$urandom()}};
      @(posedge clk);
      #1;
      chk("bp_out_valid_held", 512'(out_valid), 512'd1);
      chk("bp_in_ready_low", 512'(in_ready), 512'd0);
      chk("bp_product_held", product, 512'd20000);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    take();

    start(1'b1, ~256'd2, 256'd9);
    wait_done(33);
    chk("s_neg3_x_9", product, ~512'd26);
    take();

    start(1'b0, 256'd123, 256'd456);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 512'(out_valid), 512'd0);
    chk("midrst_product", product, 512'd0);
    chk("midrst_busy", 512'(busy), 512'd0);
    chk("midrst_in_ready", 512'(in_ready), 512'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start(1'b0, 256'd7, 256'd6);
    wait_done(33);
    chk("after_rst_7x6", product, 512'd42);
    take();

    small_run(1'b1, 8'h80, 8'h80);
    small_run(1'b0, 8'hFF, 8'hFF);
    small_run(1'b1, 8'hFF, 8'h01);
    small_run(1'b1, 8'h7F, 8'h80);
    small_run(1'b0, 8'h00, 8'hA5);
    for (int i = 0; i < 40; i++) begin
      small_run(1'($urandom_range(0, 1)), 8'($urandom()), 8'($urandom()));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
